// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator: FSM encoding,
// default 640x480@60 timing and sync polarity constants.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vga_state_e;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam logic POL_LOW  = 1'b0;
  localparam logic POL_HIGH = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counter over active/front porch/sync/back porch.
// Region flags decode count_next so the top can register them in step with count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter logic        POL    = POL_LOW,
  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int unsigned W     = $clog2(TOTAL)
) (
  input  logic         in_clock,
  input  logic         in_reset_n,
  input  logic         advance,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap,
  output logic         in_active,
  output logic         sync
);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_width
    $error("vga_axis_counter: every region width must be non-zero");
  end

  assign wrap = (count == LAST);

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (advance) begin
      count_next = wrap ? '0 : count + 1'b1;
    end
  end

  assign in_active = (count_next < ACT_END);
  assign sync      = ((count_next >= SYNC_START) && (count_next < SYNC_END)) ? POL : ~POL;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: enable FSM (start on frame boundary, drain to
// frame end), registered zero-lag raster outputs, line/frame ticks and frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        H_POL    = POL_LOW,
  parameter logic        V_POL    = POL_LOW,
  parameter int unsigned FRAME_W  = 8,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned X_W     = $clog2(H_TOTAL),
  localparam int unsigned Y_W     = $clog2(V_TOTAL)
) (
  input  logic               in_clock,
  input  logic               in_reset_n,
  input  logic               in_strobe,
  input  logic               in_enable,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_blank,
  output logic               out_active,
  output logic               out_line,
  output logic               out_screen,
  output logic [X_W-1:0]     out_x,
  output logic [Y_W-1:0]     out_y,
  output logic [FRAME_W-1:0] out_frame,
  output vga_state_e         out_state
);

  localparam logic [Y_W-1:0] Y_LAST_ACTIVE = Y_W'(V_ACTIVE - 1);

  vga_state_e     state, state_next;
  logic [X_W-1:0] h_count, h_next;
  logic [Y_W-1:0] v_count, v_next;
  logic           h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic           advance, clear, line_wrap, frame_wrap, running_next;
  logic           unused_counts;

  assign clear      = (state == ST_IDLE);
  assign advance    = in_strobe && !clear;
  assign line_wrap  = advance && h_wrap;
  assign frame_wrap = line_wrap && v_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
  ) u_h_axis (
    .in_clock(in_clock), .in_reset_n(in_reset_n), .advance(advance), .clear(clear),
    .count(h_count), .count_next(h_next), .wrap(h_wrap), .in_active(h_act), .sync(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
  ) u_v_axis (
    .in_clock(in_clock), .in_reset_n(in_reset_n), .advance(line_wrap), .clear(clear),
    .count(v_count), .count_next(v_next), .wrap(v_wrap), .in_active(v_act), .sync(v_sync)
  );

  // Registered counts are only consumed inside the axis counters.
  assign unused_counts = ^{h_count, v_count};

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (in_enable) state_next = ST_RUN;
      ST_RUN:   if (!in_enable) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (in_enable) state_next = ST_RUN;
        else if (frame_wrap) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  assign running_next = (state_next != ST_IDLE);

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state      <= ST_IDLE;
      out_hsync  <= ~H_POL;
      out_vsync  <= ~V_POL;
      out_blank  <= 1'b1;
      out_active <= 1'b0;
      out_line   <= 1'b0;
      out_screen <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_frame  <= '0;
    end else begin
      state      <= state_next;
      out_hsync  <= running_next ? h_sync : ~H_POL;
      out_vsync  <= running_next ? v_sync : ~V_POL;
      out_active <= running_next && h_act && v_act;
      out_blank  <= !(running_next && h_act && v_act);
      // Ticks fire from the wrapping edge even when it also ends a drain.
      out_line   <= line_wrap;
      out_screen <= frame_wrap;
      out_x      <= (running_next && h_act) ? h_next : '0;
      out_y      <= !running_next ? '0 : (v_act ? v_next : Y_LAST_ACTIVE);
      if (frame_wrap) begin
        out_frame <= out_frame + 1'b1;
      end
    end
  end

  assign out_state = state;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line timing, slow strobe and async reset;
// a tiny positive-polarity instance for frame wrap, drain and re-enable behaviour.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default-timing instance.
  logic       a_rst_n, a_str, a_en;
  logic       a_hs, a_vs, a_bl, a_ac, a_ln, a_sc;
  logic [9:0] a_x, a_y;
  logic [7:0] a_fr;
  vga_state_e a_st;

  vga_timing_gen u_dut_a (
    .in_clock(clk), .in_reset_n(a_rst_n), .in_strobe(a_str), .in_enable(a_en),
    .out_hsync(a_hs), .out_vsync(a_vs), .out_blank(a_bl), .out_active(a_ac),
    .out_line(a_ln), .out_screen(a_sc), .out_x(a_x), .out_y(a_y),
    .out_frame(a_fr), .out_state(a_st)
  );

  // Small instance: H 8/2/3/2 (15), V 4/1/2/1 (8), 120 clocks per frame.
  logic       b_rst_n, b_str, b_en;
  logic       b_hs, b_vs, b_bl, b_ac, b_ln, b_sc;
  logic [3:0] b_x;
  logic [2:0] b_y;
  logic [1:0] b_fr;
  vga_state_e b_st;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .FRAME_W(2)
  ) u_dut_b (
    .in_clock(clk), .in_reset_n(b_rst_n), .in_strobe(b_str), .in_enable(b_en),
    .out_hsync(b_hs), .out_vsync(b_vs), .out_blank(b_bl), .out_active(b_ac),
    .out_line(b_ln), .out_screen(b_sc), .out_x(b_x), .out_y(b_y),
    .out_frame(b_fr), .out_state(b_st)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pa = 0;
  int pb = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_to(input int p);
    while (pa < p) begin
      tick();
      pa++;
    end
  endtask

  task automatic b_to(input int p);
    while (pb < p) begin
      tick();
      pb++;
    end
  endtask

  task automatic a_strobe_once();
    a_str = 1'b1;
    tick();
    a_str = 1'b0;
    pa++;
  endtask

  initial begin
    a_rst_n = 1'b0; a_str = 1'b0; a_en = 1'b0;
    b_rst_n = 1'b0; b_str = 1'b0; b_en = 1'b0;
    #12;
    check_eq("a_rst_hsync", 32'(a_hs), 1);
    check_eq("a_rst_vsync", 32'(a_vs), 1);
    check_eq("a_rst_blank", 32'(a_bl), 1);
    check_eq("a_rst_active", 32'(a_ac), 0);
    check_eq("a_rst_line", 32'(a_ln), 0);
    check_eq("a_rst_screen", 32'(a_sc), 0);
    check_eq("a_rst_x", 32'(a_x), 0);
    check_eq("a_rst_y", 32'(a_y), 0);
    check_eq("a_rst_frame", 32'(a_fr), 0);
    check_eq("b_rst_hsync", 32'(b_hs), 0);
    check_eq("b_rst_vsync", 32'(b_vs), 0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();
    check_eq("a_idle_state", 32'(a_st), 32'(ST_IDLE));
    check_eq("a_idle_blank", 32'(a_bl), 1);

    // Default timing, one pixel per clock.
    a_en = 1'b1; a_str = 1'b1;
    tick(); pa = 0;
    check_eq("a_start_state", 32'(a_st), 32'(ST_RUN));
    check_eq("a_start_active", 32'(a_ac), 1);
    check_eq("a_start_x", 32'(a_x), 0);
    check_eq("a_start_hsync", 32'(a_hs), 1);
    a_to(639);  check_eq("a_x639", 32'(a_x), 639);
                check_eq("a_act639", 32'(a_ac), 1);
    a_to(640);  check_eq("a_x640", 32'(a_x), 0);
                check_eq("a_blank640", 32'(a_bl), 1);
    a_to(655);  check_eq("a_hs655", 32'(a_hs), 1);
    a_to(656);  check_eq("a_hs656", 32'(a_hs), 0);
    a_to(751);  check_eq("a_hs751", 32'(a_hs), 0);
    a_to(752);  check_eq("a_hs752", 32'(a_hs), 1);
    a_to(799);  check_eq("a_line799", 32'(a_ln), 0);
    a_to(800);  check_eq("a_line800", 32'(a_ln), 1);
                check_eq("a_y800", 32'(a_y), 1);
                check_eq("a_x800", 32'(a_x), 0);
    a_to(801);  check_eq("a_line801", 32'(a_ln), 0);
    a_to(1600); check_eq("a_line1600", 32'(a_ln), 1);
                check_eq("a_y1600", 32'(a_y), 2);

    // Asynchronous reset mid-line, away from the clock edge.
    a_to(1900); check_eq("a_x300", 32'(a_x), 300);
    a_rst_n = 1'b0;
    #2;
    check_eq("a_arst_state", 32'(a_st), 32'(ST_IDLE));
    check_eq("a_arst_blank", 32'(a_bl), 1);
    check_eq("a_arst_active", 32'(a_ac), 0);
    check_eq("a_arst_x", 32'(a_x), 0);
    check_eq("a_arst_y", 32'(a_y), 0);
    check_eq("a_arst_hsync", 32'(a_hs), 1);
    a_rst_n = 1'b1;
    tick(); pa = 0;
    check_eq("a_restart_x", 32'(a_x), 0);
    check_eq("a_restart_active", 32'(a_ac), 1);

    // One strobe every four clocks.
    a_str = 1'b0;
    a_strobe_once();
    check_eq("a_slow_x1", 32'(a_x), 1);
    repeat (3) tick();
    check_eq("a_slow_hold_x", 32'(a_x), 1);
    check_eq("a_slow_hold_act", 32'(a_ac), 1);
    while (pa < 799) begin
      repeat (3) tick();
      a_strobe_once();
    end
    check_eq("a_slow_line799", 32'(a_ln), 0);
    repeat (3) tick();
    a_strobe_once();
    check_eq("a_slow_line800", 32'(a_ln), 1);
    check_eq("a_slow_y800", 32'(a_y), 1);
    tick();
    check_eq("a_slow_line_end", 32'(a_ln), 0);
    check_eq("a_slow_y_hold", 32'(a_y), 1);
    a_en = 1'b0;

    // Small instance: frame timing, positive syncs, 2-bit frame wrap.
    b_str = 1'b1; b_en = 1'b1;
    tick(); pb = 0;
    check_eq("b_start_x", 32'(b_x), 0);
    check_eq("b_start_active", 32'(b_ac), 1);
    check_eq("b_start_hsync", 32'(b_hs), 0);
    b_to(7);   check_eq("b_x7", 32'(b_x), 7);
    b_to(8);   check_eq("b_blank8", 32'(b_bl), 1);
    b_to(9);   check_eq("b_hs9", 32'(b_hs), 0);
    b_to(10);  check_eq("b_hs10", 32'(b_hs), 1);
    b_to(12);  check_eq("b_hs12", 32'(b_hs), 1);
    b_to(13);  check_eq("b_hs13", 32'(b_hs), 0);
    b_to(15);  check_eq("b_line15", 32'(b_ln), 1);
               check_eq("b_y15", 32'(b_y), 1);
    b_to(16);  check_eq("b_line16", 32'(b_ln), 0);
    b_to(60);  check_eq("b_y_vblank", 32'(b_y), 3);
               check_eq("b_act_vblank", 32'(b_ac), 0);
    b_to(74);  check_eq("b_vs74", 32'(b_vs), 0);
    b_to(75);  check_eq("b_vs75", 32'(b_vs), 1);
    b_to(90);  check_eq("b_vs90", 32'(b_vs), 1);
    b_to(105); check_eq("b_vs105", 32'(b_vs), 0);
    b_to(119); check_eq("b_screen119", 32'(b_sc), 0);
               check_eq("b_frame119", 32'(b_fr), 0);
    b_to(120); check_eq("b_screen120", 32'(b_sc), 1);
               check_eq("b_frame120", 32'(b_fr), 1);
               check_eq("b_act120", 32'(b_ac), 1);
    b_to(121); check_eq("b_screen121", 32'(b_sc), 0);
    b_to(360); check_eq("b_frame3", 32'(b_fr), 3);
    b_to(480); check_eq("b_frame_wrap", 32'(b_fr), 0);

    // Drop enable mid-frame: finish the frame, then idle.
    b_to(510); b_en = 1'b0;
    b_to(511); check_eq("b_drain_state", 32'(b_st), 32'(ST_DRAIN));
    b_to(555); check_eq("b_drain_line", 32'(b_ln), 1);
               check_eq("b_drain_vsync", 32'(b_vs), 1);
    b_to(599); check_eq("b_drain_last", 32'(b_st), 32'(ST_DRAIN));
    b_to(600); check_eq("b_end_screen", 32'(b_sc), 1);
               check_eq("b_end_frame", 32'(b_fr), 1);
               check_eq("b_end_state", 32'(b_st), 32'(ST_IDLE));
               check_eq("b_end_blank", 32'(b_bl), 1);
               check_eq("b_end_y", 32'(b_y), 0);
    b_to(601); check_eq("b_idle_screen", 32'(b_sc), 0);
               check_eq("b_idle_hsync", 32'(b_hs), 0);
    b_to(630); check_eq("b_idle_frame", 32'(b_fr), 1);
               check_eq("b_idle_x", 32'(b_x), 0);

    // Brief deassert and reassert inside a frame: raster undisturbed.
    b_en = 1'b1;
    tick(); pb = 0;
    check_eq("b_re_state", 32'(b_st), 32'(ST_RUN));
    check_eq("b_re_x", 32'(b_x), 0);
    b_to(20);  check_eq("b_re_x20", 32'(b_x), 5);
               check_eq("b_re_y20", 32'(b_y), 1);
    b_en = 1'b0;
    b_to(21);  check_eq("b_blip_state", 32'(b_st), 32'(ST_DRAIN));
               check_eq("b_blip_x", 32'(b_x), 6);
    b_en = 1'b1;
    b_to(22);  check_eq("b_back_state", 32'(b_st), 32'(ST_RUN));
               check_eq("b_back_x", 32'(b_x), 7);
    b_to(29);  check_eq("b_re_line29", 32'(b_ln), 0);
    b_to(30);  check_eq("b_re_line30", 32'(b_ln), 1);
               check_eq("b_re_y30", 32'(b_y), 2);
    b_to(44);  check_eq("b_re_line44", 32'(b_ln), 0);
    b_to(45);  check_eq("b_re_line45", 32'(b_ln), 1);
               check_eq("b_re_frame", 32'(b_fr), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
